// File: rtl/cache_req_sequencer_pkg.sv
// Shared types and default widths for the cache request sequencer.
package cache_seq_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        RESP
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } cache_req_t;

endpackage

// File: rtl/cache_req_sequencer_if.sv
// Request, controller and response signals of the cache request sequencer.
// slave = the sequencer itself, master = the surrounding environment.
interface cache_req_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_wr;
    logic [ADDR_W-1:0] o_cc_address;
    logic              o_cc_start;
    logic              o_cc_wr;
    logic              o_cc_en;
    logic [DATA_W-1:0] i_cc_data;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;
    logic [ADDR_W-1:0] o_rsp_addr;
    logic              o_busy;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wr, i_cc_data, i_rsp_ready,
        output o_req_ready, o_cc_address, o_cc_start, o_cc_wr, o_cc_en,
               o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_wr, i_cc_data, i_rsp_ready,
        input  o_req_ready, o_cc_address, o_cc_start, o_cc_wr, o_cc_en,
               o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy
    );
endinterface

// File: rtl/cache_req_sequencer_req_fifo.sv
// Small synchronous FIFO holding queued requests; DEPTH must be a power of two.
module req_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push is refused whenever full, even if a pop happens in the same cycle.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since pointers/count gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cache_req_sequencer.sv
// Queues processor requests and plays them one at a time into the cache
// controller: start pulse, fixed wait, data capture, optional read response.
module cache_req_sequencer #(
    parameter int ADDR_W      = cache_seq_pkg::ADDR_W,
    parameter int DATA_W      = cache_seq_pkg::DATA_W,
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cache_req_sequencer_if.slave  bus
);
    import cache_seq_pkg::*;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int EW    = ADDR_W + 1;

    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_wr;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              push, pop, full, empty;
    logic [EW-1:0]     push_data, pop_data;

    assign push      = bus.i_req_valid && !full;
    assign push_data = {bus.i_req_addr, bus.i_req_wr};
    assign pop       = (state == IDLE) && !empty;

    req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (pop_data),
        .full     (full),
        .empty    (empty)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: one request in flight, strictly in FIFO order.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = cur_wr ? IDLE : RESP;
            RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current request, wait counter and response holding registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_addr <= '0;
            cur_wr   <= 1'b0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_addr <= '0;
        end else begin
            if (pop) {cur_addr, cur_wr} <= pop_data;
            if (state == START)
                wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - CNT_W'(1);
            if (state == CAPTURE) begin
                rsp_data <= bus.i_cc_data;
                rsp_addr <= cur_addr;
            end
        end
    end

    // Outputs decoded from state; address/wr held in cur_* for the whole access.
    always_comb begin
        bus.o_cc_start  = (state == START);
        bus.o_cc_en     = (state == START) || (state == WAIT) || (state == CAPTURE);
        bus.o_rsp_valid = (state == RESP);
        bus.o_busy      = (state != IDLE) || !empty;
    end

    assign bus.o_req_ready  = !full;
    assign bus.o_cc_address = cur_addr;
    assign bus.o_cc_wr      = cur_wr;
    assign bus.o_rsp_data   = rsp_data;
    assign bus.o_rsp_addr   = rsp_addr;
endmodule

// File: tb/tb_cache_req_sequencer.sv
// Directed bench for cache_req_sequencer with a trivial controller model.
module tb_cache_req_sequencer;
    import cache_seq_pkg::*;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic fixed_data;
    int   errors  = 0;
    int   checks  = 0;

    always #5 i_clk = ~i_clk;

    cache_req_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_req_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4), .WAIT_CYCLES(4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    // Controller model: either a fixed word or an address-tagged pattern.
    function automatic logic [31:0] cc_word(logic [4:0] a);
        return {16'hC0DE, 11'h000, a};
    endfunction
    assign bus.i_cc_data = fixed_data ? 32'hDEADBEEF : cc_word(bus.o_cc_address);

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    int          start_n, start_c, rsp_c, rsp_n, sent, sent5;
    logic [31:0] data0;
    logic        stable;
    logic        rdy [32];
    int          starts[$];
    logic        start_wr[$];
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];
    logic [4:0]  rsp_a;
    logic [31:0] rsp_d;
    cache_req_t  r;

    initial begin
        fixed_data      = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wr    = 1'b0;
        bus.i_rsp_ready = 1'b0;

        // Reset state
        step;
        @(negedge i_clk);
        chk("rst_ready",    32'(bus.o_req_ready),  32'd1);
        chk("rst_busy",     32'(bus.o_busy),       32'd0);
        chk("rst_rsp_vld",  32'(bus.o_rsp_valid),  32'd0);
        chk("rst_cc_en",    32'(bus.o_cc_en),      32'd0);
        chk("rst_cc_start", 32'(bus.o_cc_start),   32'd0);
        chk("rst_cc_addr",  32'(bus.o_cc_address), 32'd0);
        chk("rst_rsp_data", bus.o_rsp_data,        32'd0);
        chk("rst_rsp_addr", 32'(bus.o_rsp_addr),   32'd0);
        step;
        i_rst_n = 1'b1;
        step;

        // Single read of 0x0A, response held off for 11 cycles
        fixed_data = 1'b1;
        r = '{addr: 5'h0A, wr: 1'b0};
        bus.i_req_valid = 1'b1;
        {bus.i_req_addr, bus.i_req_wr} = r;
        step;
        bus.i_req_valid = 1'b0;
        start_n = 0; start_c = -1; rsp_c = -1; data0 = '0; stable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge i_clk);
            if (bus.o_cc_start) begin start_n++; start_c = c; end
            if (bus.o_rsp_valid && rsp_c < 0) begin rsp_c = c; data0 = bus.o_rsp_data; end
            if (c > 8 && (bus.o_rsp_data !== data0 || bus.o_cc_start || !bus.o_rsp_valid))
                stable = 1'b0;
            step;
        end
        chk("rd_start_count", start_n, 1);
        chk("rd_start_cycle", start_c, 2);
        chk("rd_rsp_cycle",   rsp_c,   8);
        chk("rd_rsp_data",    bus.o_rsp_data, 32'hDEADBEEF);
        chk("rd_rsp_addr",    32'(bus.o_rsp_addr), 32'h0A);
        chk("rd_hold_stable", 32'(stable), 32'd1);
        bus.i_rsp_ready = 1'b1;
        @(negedge i_clk);
        chk("rd_vld_at_ready", 32'(bus.o_rsp_valid), 32'd1);
        step;
        @(negedge i_clk);
        chk("rd_vld_after", 32'(bus.o_rsp_valid), 32'd0);
        chk("rd_idle_busy", 32'(bus.o_busy),      32'd0);
        step;

        // Write 0x03 then read 0x04
        fixed_data = 1'b0;
        rsp_n = 0; rsp_c = -1; rsp_a = '0; rsp_d = '0;
        for (int c = 0; c < 26; c++) begin
            bus.i_req_valid = (c < 2);
            bus.i_req_addr  = (c == 0) ? 5'h03 : 5'h04;
            bus.i_req_wr    = (c == 0);
            @(negedge i_clk);
            if (bus.o_cc_start) begin starts.push_back(c); start_wr.push_back(bus.o_cc_wr); end
            if (bus.o_rsp_valid) begin
                rsp_n++; rsp_c = c; rsp_a = bus.o_rsp_addr; rsp_d = bus.o_rsp_data;
            end
            step;
        end
        chk("wr_start_count", starts.size(), 2);
        chk("wr_start_cycle", (starts.size() > 0) ? starts[0] : -1, 2);
        chk("wr_rd_spacing",  (starts.size() > 1) ? starts[1] - starts[0] : -1, 7);
        chk("wr_cc_wr",       (start_wr.size() > 0) ? 32'(start_wr[0]) : 32'hX, 32'd1);
        chk("rd2_cc_wr",      (start_wr.size() > 1) ? 32'(start_wr[1]) : 32'hX, 32'd0);
        chk("wr_rsp_count",   rsp_n, 1);
        chk("rd2_rsp_cycle",  rsp_c, 15);
        chk("rd2_rsp_addr",   32'(rsp_a), 32'h04);
        chk("rd2_rsp_data",   rsp_d, 32'hC0DE0004);

        // Six reads back-to-back, responses stalled until cycle 12
        sent = 0; sent5 = -1;
        for (int c = 0; c < 200 && got_a.size() < 6; c++) begin
            bus.i_req_valid = (sent < 6);
            bus.i_req_addr  = 5'(5'h10 + sent);
            bus.i_req_wr    = 1'b0;
            bus.i_rsp_ready = (c >= 12);
            @(negedge i_clk);
            if (c < 32) rdy[c] = bus.o_req_ready;
            if (c == 5) sent5 = sent;
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                got_a.push_back(bus.o_rsp_addr);
                got_d.push_back(bus.o_rsp_data);
            end
            if (bus.i_req_valid && bus.o_req_ready) sent++;
            step;
        end
        bus.i_req_valid = 1'b0;
        chk("fill_sent_by_c5",   sent5, 5);
        chk("fill_ready_c4",     32'(rdy[4]),  32'd1);
        chk("fill_ready_c5",     32'(rdy[5]),  32'd0);
        chk("full_pop_ready",    32'(rdy[13]), 32'd0);
        chk("after_pop_ready",   32'(rdy[14]), 32'd1);
        chk("fill_rsp_count",    got_a.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_a.size()) begin
                chk($sformatf("order_addr%0d", i), 32'(got_a[i]), 32'(5'h10 + i));
                chk($sformatf("order_data%0d", i), got_d[i], 32'hC0DE0010 + 32'(i));
            end
        end
        bus.i_rsp_ready = 1'b0;
        step;

        // Reset while a read is in WAIT with another queued
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 5'h1A;
        step;
        bus.i_req_addr  = 5'h1B;
        step;
        bus.i_req_valid = 1'b0;
        step;
        step;
        @(negedge i_clk);
        chk("wait_cc_en", 32'(bus.o_cc_en), 32'd1);
        chk("wait_busy",  32'(bus.o_busy),  32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy",  32'(bus.o_busy),      32'd0);
        chk("midrst_cc_en", 32'(bus.o_cc_en),     32'd0);
        chk("midrst_ready", 32'(bus.o_req_ready), 32'd1);
        step;
        step;
        i_rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        rsp_n = 0; start_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge i_clk);
            if (bus.o_rsp_valid) rsp_n++;
            if (bus.o_cc_start)  start_n++;
            step;
        end
        chk("midrst_no_rsp",   rsp_n,   0);
        chk("midrst_no_start", start_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
